// File: rtl/test_run_sequencer_pkg.sv
// Shared types for the test-run sequencer: FSM states, result codes and default widths.
package test_run_pkg;

   typedef enum logic [1:0] {
      HOLD   = 2'd0,
      RUN    = 2'd1,
      REPORT = 2'd2,
      PARKED = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      RES_PASS    = 2'd0,
      RES_FAIL    = 2'd1,
      RES_TIMEOUT = 2'd2
   } result_e;

   localparam int DEF_CNT_W = 64;

endpackage

// File: rtl/test_run_sequencer_if.sv
// Result handshake: result_code is meaningful only while result_valid is high, and a
// transfer happens on a rising edge with result_valid && result_ready; valid never drops before then.
interface test_run_sequencer_if;
   import test_run_pkg::*;

   logic    result_valid;
   logic    result_ready;
   result_e result_code;

   modport master (output result_valid, output result_code, input result_ready);
   modport slave  (input result_valid, input result_code, output result_ready);

endinterface

// File: rtl/test_run_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-low reset.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         en,
   input  logic         clr,
   output logic [W-1:0] count
);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && (count != {W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/test_run_sequencer.sv
// Run controller: releases DUT core reset, runs the watchdog, gates dumping and reports
// a single pass/fail/timeout result over the result handshake.
module test_run_sequencer
   import test_run_pkg::*;
#(
   parameter int          RESET_CYCLES = 8,
   parameter int          PC_W         = 40,
   parameter logic [PC_W-1:0] BOOT_PC  = 40'h8000_0000,
   parameter int          CNT_W        = DEF_CNT_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [CNT_W-1:0] max_cycles,
   input  logic [CNT_W-1:0] dump_start,
   input  logic             success,
   input  logic             failure,
   output logic             core_reset,
   output logic             pc_override_valid,
   output logic [PC_W-1:0]  pc_override,
   output logic             dump_en,
   output logic [CNT_W-1:0] cycle_count,
   output state_e           dbg_state,
   test_run_sequencer_if.master res
);

   localparam int HOLD_W = $clog2(RESET_CYCLES + 1);

   state_e           state, state_n;
   result_e          code_q, code_n;
   logic [HOLD_W-1:0] hold_cnt;
   logic [CNT_W-1:0] run_cnt;
   logic [CNT_W-1:0] max_lat;
   logic [CNT_W-1:0] dump_lat;
   logic [CNT_W-1:0] cfg_dump;
   logic             timeout;
   logic             counting;
   logic             enter_report;

   sat_counter #(.W(HOLD_W)) u_hold_cnt (
      .clock (clock),
      .reset (reset),
      .en    (state == HOLD),
      .clr   (state != HOLD),
      .count (hold_cnt)
   );

   sat_counter #(.W(CNT_W)) u_run_cnt (
      .clock (clock),
      .reset (reset),
      .en    (state == RUN),
      .clr   (state == HOLD),
      .count (run_cnt)
   );

   assign counting = (state == HOLD) || (state == RUN);

   sat_counter #(.W(CNT_W)) u_cycle_cnt (
      .clock (clock),
      .reset (reset),
      .en    (counting),
      .clr   (1'b0),
      .count (cycle_count)
   );

   // While in HOLD the latch is still tracking the input, so compare against the live value.
   assign cfg_dump = (state == HOLD) ? dump_start : dump_lat;
   assign timeout  = (max_lat != '0) && (run_cnt == max_lat);

   always_comb begin
      state_n = state;
      code_n  = code_q;
      case (state)
         HOLD: begin
            if (hold_cnt == HOLD_W'(RESET_CYCLES - 1)) state_n = RUN;
         end
         RUN: begin
            if (failure) begin
               state_n = REPORT;
               code_n  = RES_FAIL;
            end else if (timeout) begin
               state_n = REPORT;
               code_n  = RES_TIMEOUT;
            end else if (success) begin
               state_n = REPORT;
               code_n  = RES_PASS;
            end
         end
         REPORT: begin
            if (res.result_ready) state_n = PARKED;
         end
         PARKED: state_n = PARKED;
         default: state_n = HOLD;
      endcase
   end

   assign enter_report = (state == RUN) && (state_n == REPORT);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= HOLD;
         code_q   <= RES_PASS;
         max_lat  <= '0;
         dump_lat <= '0;
         dump_en  <= 1'b0;
      end else begin
         state  <= state_n;
         code_q <= code_n;
         if (state == HOLD) begin
            max_lat  <= max_cycles;
            dump_lat <= dump_start;
         end
         if (enter_report) begin
            dump_en <= 1'b0;
         end else if (counting && (cycle_count == cfg_dump)) begin
            dump_en <= 1'b1;
         end
      end
   end

   assign core_reset        = (state != RUN);
   assign pc_override_valid = (state == HOLD);
   assign pc_override       = BOOT_PC;
   assign dbg_state         = state;
   assign res.result_valid  = (state == REPORT);
   assign res.result_code   = code_q;

endmodule

// File: tb/tb_test_run_sequencer.sv
// Directed bench for test_run_sequencer with an expected-result queue checked by a monitor.
module tb_test_run_sequencer;
   import test_run_pkg::*;

   localparam int          RC   = 4;
   localparam int          W    = 18;
   localparam logic [39:0] BOOT = 40'h8000_0000;

   logic        clock = 1'b0;
   logic        reset;
   logic [63:0] max_cycles;
   logic [63:0] dump_start;
   logic        success;
   logic        failure;
   logic        core_reset;
   logic        pc_override_valid;
   logic [39:0] pc_override;
   logic        dump_en;
   logic [63:0] cycle_count;
   state_e      dbg_state;

   test_run_sequencer_if res ();

   test_run_sequencer #(.RESET_CYCLES(RC)) dut (
      .clock             (clock),
      .reset             (reset),
      .max_cycles        (max_cycles),
      .dump_start        (dump_start),
      .success           (success),
      .failure           (failure),
      .core_reset        (core_reset),
      .pc_override_valid (pc_override_valid),
      .pc_override       (pc_override),
      .dump_en           (dump_en),
      .cycle_count       (cycle_count),
      .dbg_state         (dbg_state),
      .res               (res.master)
   );

   // clock / reset
   always #5 clock = ~clock;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [W-1:0] exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [1:0] code, input int cc);
      exp_q.push_back({code, cc[15:0]});
   endtask

   // drivers
   task automatic do_reset(input logic [63:0] maxc, input logic [63:0] dstart);
      reset      = 1'b0;
      max_cycles = maxc;
      dump_start = dstart;
      success    = 1'b0;
      failure    = 1'b0;
      repeat (2) @(negedge clock);
      check("rst_core_reset", 64'(core_reset), 64'd1);
      check("rst_pc_ov_valid", 64'(pc_override_valid), 64'd1);
      check("rst_pc_override", 64'(pc_override), 64'(BOOT));
      check("rst_dump_en", 64'(dump_en), 64'd0);
      check("rst_cycle_count", cycle_count, 64'd0);
      check("rst_result_valid", 64'(res.result_valid), 64'd0);
      check("rst_result_code", 64'(res.result_code), 64'd0);
      check("rst_state", 64'(dbg_state), 64'(HOLD));
      reset = 1'b1;
   endtask

   task automatic pulse(input logic s, input logic f);
      success = s;
      failure = f;
      @(negedge clock);
      success = 1'b0;
      failure = 1'b0;
   endtask

   // scoreboard monitor
   logic seen = 1'b0;
   initial begin
      logic [W-1:0] e;
      forever begin
         @(negedge clock);
         if (res.result_valid && !seen) begin
            seen = 1'b1;
            if (exp_q.size() == 0) begin
               check("result_unexpected", 64'(res.result_valid), 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("result_code_cc", 64'({2'(res.result_code), cycle_count[15:0]}), 64'(e));
            end
         end else if (!res.result_valid) begin
            seen = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "bench watchdog expired");
   end

   initial begin
      reset = 1'b1;
      res.result_ready = 1'b0;
      #1;

      // Test 1: reset release timing, success on RUN cycle 10
      do_reset(64'd0, 64'd100);
      for (int k = 1; k <= RC; k++) begin
         @(negedge clock);
         check("rel_core_reset", 64'(core_reset), 64'(k < RC));
         check("rel_pc_ov_valid", 64'(pc_override_valid), 64'(k < RC));
         check("rel_cycle_count", cycle_count, 64'(k));
      end
      repeat (10) @(negedge clock);
      push_exp(2'd0, RC + 10 + 1);
      pulse(1'b1, 1'b0);
      check("t1_valid", 64'(res.result_valid), 64'd1);
      check("t1_core_reset", 64'(core_reset), 64'd1);
      res.result_ready = 1'b1;
      @(negedge clock);
      check("t1_parked", 64'(dbg_state), 64'(PARKED));
      check("t1_valid_low", 64'(res.result_valid), 64'd0);
      res.result_ready = 1'b0;

      // Test 2: failure with success, ready already high -> one-cycle valid
      do_reset(64'd0, 64'd100);
      res.result_ready = 1'b1;
      repeat (RC + 3) @(negedge clock);
      push_exp(2'd1, RC + 3 + 1);
      pulse(1'b1, 1'b1);
      check("t2_valid", 64'(res.result_valid), 64'd1);
      check("t2_core_reset", 64'(core_reset), 64'd1);
      @(negedge clock);
      check("t2_valid_1cyc", 64'(res.result_valid), 64'd0);
      check("t2_parked", 64'(dbg_state), 64'(PARKED));
      res.result_ready = 1'b0;

      // Test 3: timeout at 20 with dump_start=0, ready held off 5 cycles
      do_reset(64'd20, 64'd0);
      push_exp(2'd2, RC + 20 + 1);
      @(negedge clock);
      check("t3_dump_early", 64'(dump_en), 64'd1);
      check("t3_cc1", cycle_count, 64'd1);
      repeat (RC + 20 - 1) @(negedge clock);
      check("t3_not_yet", 64'(res.result_valid), 64'd0);
      @(negedge clock);
      check("t3_dump_cleared", 64'(dump_en), 64'd0);
      for (int i = 0; i < 5; i++) begin
         check("t3_hold_valid", 64'(res.result_valid), 64'd1);
         check("t3_hold_code", 64'(res.result_code), 64'd2);
         check("t3_cc_frozen", cycle_count, 64'(RC + 21));
         if (i < 4) @(negedge clock);
      end
      res.result_ready = 1'b1;
      @(negedge clock);
      check("t3_parked", 64'(dbg_state), 64'(PARKED));
      check("t3_valid_low", 64'(res.result_valid), 64'd0);
      check("t3_code_held", 64'(res.result_code), 64'd2);
      res.result_ready = 1'b0;

      // Test 4: success on the timeout cycle -> TIMEOUT
      do_reset(64'd20, 64'd100);
      res.result_ready = 1'b1;
      repeat (RC + 20) @(negedge clock);
      push_exp(2'd2, RC + 21);
      pulse(1'b1, 1'b0);
      check("t4_valid", 64'(res.result_valid), 64'd1);
      @(negedge clock);

      // Test 5: failure on the timeout cycle -> FAIL
      do_reset(64'd20, 64'd100);
      repeat (RC + 20) @(negedge clock);
      push_exp(2'd1, RC + 21);
      pulse(1'b0, 1'b1);
      check("t5_valid", 64'(res.result_valid), 64'd1);
      @(negedge clock);

      // Test 6: dump_start=15, success on RUN cycle 15
      do_reset(64'd0, 64'd15);
      repeat (15) @(negedge clock);
      check("t6_cc15", cycle_count, 64'd15);
      check("t6_dump_before", 64'(dump_en), 64'd0);
      @(negedge clock);
      check("t6_dump_set", 64'(dump_en), 64'd1);
      repeat (3) @(negedge clock);
      push_exp(2'd0, RC + 15 + 1);
      pulse(1'b1, 1'b0);
      check("t6_dump_cleared", 64'(dump_en), 64'd0);
      @(negedge clock);

      // Test 7: asynchronous reset mid-RUN, new max_cycles latched
      do_reset(64'd50, 64'd1000);
      repeat (RC + 5) @(negedge clock);
      check("t7_in_run", 64'(dbg_state), 64'(RUN));
      #2 reset = 1'b0;
      #1;
      check("t7_async_state", 64'(dbg_state), 64'(HOLD));
      check("t7_async_core_reset", 64'(core_reset), 64'd1);
      check("t7_async_cc", cycle_count, 64'd0);
      max_cycles = 64'd6;
      @(negedge clock);
      reset = 1'b1;
      push_exp(2'd2, RC + 6 + 1);
      repeat (RC + 6 + 1) @(negedge clock);
      check("t7_timeout_valid", 64'(res.result_valid), 64'd1);
      @(negedge clock);

      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
